// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: parallel load, shifts, rotates and ASR.
// Includes a saturating serial fill counter and frame-done pulse for SIPO/PISO use.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CW-1:0]    bit_cnt,
    output logic             full,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROTL = 3'b100,
        M_ROTR = 3'b101,
        M_ASR  = 3'b110,
        M_CLR  = 3'b111
    } mode_e;

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    // Compare against the ceiling before incrementing so the count never wraps.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CNT_MAX) ? c : c + CW'(1);
    endfunction

    function automatic logic [WIDTH-1:0] asr1(input logic signed [WIDTH-1:0] v);
        return WIDTH'(v >>> 1);
    endfunction

    mode_e            op;
    logic [WIDTH-1:0] r_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             fd_nxt;

    assign op = mode_e'(mode);

    always_comb begin
        r_nxt   = pout;
        cnt_nxt = bit_cnt;
        fd_nxt  = 1'b0;
        if (en) begin
            case (op)
                M_HOLD: ;
                M_LOAD: begin
                    r_nxt   = pin;
                    cnt_nxt = CNT_MAX;
                end
                M_SHL: begin
                    r_nxt   = {pout[WIDTH-2:0], sin_r};
                    cnt_nxt = sat_inc(bit_cnt);
                    fd_nxt  = (bit_cnt == CNT_MAX - CW'(1));
                end
                M_SHR: begin
                    r_nxt   = {sin_l, pout[WIDTH-1:1]};
                    cnt_nxt = sat_inc(bit_cnt);
                    fd_nxt  = (bit_cnt == CNT_MAX - CW'(1));
                end
                M_ROTL: r_nxt = {pout[WIDTH-2:0], pout[WIDTH-1]};
                M_ROTR: r_nxt = {pout[0], pout[WIDTH-1:1]};
                M_ASR:  r_nxt = asr1(pout);
                M_CLR: begin
                    r_nxt   = '0;
                    cnt_nxt = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pout       <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            pout       <= r_nxt;
            bit_cnt    <= cnt_nxt;
            frame_done <= fd_nxt;
        end
    end

    assign sout_l = pout[WIDTH-1];
    assign sout_r = pout[0];
    assign full   = (bit_cnt == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg at WIDTH=4, 8 and 2 with hand-computed vectors.
module tb_univ_shift_reg;

    localparam logic [2:0] M_HOLD = 3'd0, M_LOAD = 3'd1, M_SHL = 3'd2, M_SHR = 3'd3,
                           M_ROTL = 3'd4, M_ROTR = 3'd5, M_ASR = 3'd6, M_CLR = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'd0;
    logic       sin_l = 1'b0;
    logic       sin_r = 1'b0;
    logic [7:0] pin = 8'h00;

    logic [3:0] pout4;  logic [2:0] cnt4;  logic sl4, sr4, full4, fd4;
    logic [7:0] pout8;  logic [3:0] cnt8;  logic sl8, sr8, full8, fd8;
    logic [1:0] pout2;  logic [1:0] cnt2;  logic sl2, sr2, full2, fd2;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
        .pin(pin[3:0]), .pout(pout4), .sout_l(sl4), .sout_r(sr4), .bit_cnt(cnt4),
        .full(full4), .frame_done(fd4));

    univ_shift_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
        .pin(pin), .pout(pout8), .sout_l(sl8), .sout_r(sr8), .bit_cnt(cnt8),
        .full(full8), .frame_done(fd8));

    univ_shift_reg #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
        .pin(pin[1:0]), .pout(pout2), .sout_l(sl2), .sout_r(sr2), .bit_cnt(cnt2),
        .full(full2), .frame_done(fd2));

    typedef struct {
        int         sel;
        string      nm;
        logic [7:0] ep;
        int         ec;
        logic       efd;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    event chk_ev;

    task automatic push_exp(input int sel, input string nm, input logic [7:0] ep,
                            input int ec, input logic efd);
        exp_t x;
        x.sel = sel; x.nm = nm; x.ep = ep; x.ec = ec; x.efd = efd;
        q.push_back(x);
    endtask

    task automatic step(input int sel, input string nm, input logic e, input logic [2:0] m,
                        input logic sl, input logic sr, input logic [7:0] p,
                        input logic [7:0] ep, input int ec, input logic efd);
        @(negedge clk);
        en = e; mode = m; sin_l = sl; sin_r = sr; pin = p;
        push_exp(sel, nm, ep, ec, efd);
    endtask

    // Reset lands between edges so the check proves the clear is asynchronous.
    task automatic async_reset(input int sel);
        @(posedge clk);
        #3;
        rst = 1'b0;
        en  = 1'b0;
        if (sel < 0) begin
            push_exp(0, "reset4", 8'h00, 0, 1'b0);
            push_exp(1, "reset8", 8'h00, 0, 1'b0);
            push_exp(2, "reset2", 8'h00, 0, 1'b0);
        end else begin
            push_exp(sel, "reset_mid", 8'h00, 0, 1'b0);
        end
        ->chk_ev;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check(input exp_t x);
        int w;
        logic [7:0] ap;
        int ac;
        logic afd, afull, asl, asr, esl, esr, efull;
        case (x.sel)
            0: begin w = 4; ap = {4'b0, pout4}; ac = int'(cnt4); afd = fd4; afull = full4; asl = sl4; asr = sr4; end
            1: begin w = 8; ap = pout8; ac = int'(cnt8); afd = fd8; afull = full8; asl = sl8; asr = sr8; end
            default: begin w = 2; ap = {6'b0, pout2}; ac = int'(cnt2); afd = fd2; afull = full2; asl = sl2; asr = sr2; end
        endcase
        esl   = x.ep[w-1];
        esr   = x.ep[0];
        efull = (x.ec == w);
        total++;
        if (ap !== x.ep || ac != x.ec || afd !== x.efd || afull !== efull ||
            asl !== esl || asr !== esr) begin
            bad++;
            $display("FAIL %s (W=%0d): got pout=%h cnt=%0d fd=%b full=%b sl=%b sr=%b, want pout=%h cnt=%0d fd=%b full=%b sl=%b sr=%b",
                     x.nm, w, ap, ac, afd, afull, asl, asr, x.ep, x.ec, x.efd, efull, esl, esr);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            while (q.size() > 0) begin
                x = q.pop_front();
                check(x);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        // WIDTH=4 suite
        async_reset(-1);
        release_rst();
        step(0, "load1010", 1, M_LOAD, 0, 0, 8'b1010, 8'b1010, 4, 0);
        for (int m = 0; m < 8; m++)
            step(0, "en0_gate", 0, 3'(m), 1, 1, 8'hFF, 8'b1010, 4, 0);
        step(0, "clr",       1, M_CLR,  0, 0, 0, 8'b0000, 0, 0);
        step(0, "fill1",     1, M_SHL,  0, 1, 0, 8'b0001, 1, 0);
        step(0, "fill2",     1, M_SHL,  0, 0, 0, 8'b0010, 2, 0);
        step(0, "fill3",     1, M_SHL,  0, 0, 0, 8'b0100, 3, 0);
        step(0, "fill4",     1, M_SHL,  0, 1, 0, 8'b1001, 4, 1);
        step(0, "pulse_en0", 0, M_SHL,  0, 1, 0, 8'b1001, 4, 0);
        step(0, "shl_sat",   1, M_SHL,  0, 1, 0, 8'b0011, 4, 0);
        step(0, "rotr_back", 1, M_ROTR, 0, 0, 0, 8'b1001, 4, 0);
        step(0, "rotl",      1, M_ROTL, 0, 0, 0, 8'b0011, 4, 0);
        step(0, "rotr",      1, M_ROTR, 0, 0, 0, 8'b1001, 4, 0);
        step(0, "asr",       1, M_ASR,  0, 0, 0, 8'b1100, 4, 0);
        step(0, "shr",       1, M_SHR,  0, 0, 0, 8'b0110, 4, 0);
        step(0, "clr2",      1, M_CLR,  0, 0, 0, 8'b0000, 0, 0);
        step(0, "part_shl",  1, M_SHL,  0, 1, 0, 8'b0001, 1, 0);
        step(0, "part_rotl", 1, M_ROTL, 0, 0, 0, 8'b0010, 1, 0);
        step(0, "part_rotr", 1, M_ROTR, 0, 0, 0, 8'b0001, 1, 0);
        step(0, "part_asr",  1, M_ASR,  0, 0, 0, 8'b0000, 1, 0);
        step(0, "piso_load", 1, M_LOAD, 0, 0, 8'b1110, 8'b1110, 4, 0);
        step(0, "piso1",     1, M_SHL,  0, 0, 0, 8'b1100, 4, 0);
        step(0, "piso2",     1, M_SHL,  0, 0, 0, 8'b1000, 4, 0);
        step(0, "piso3",     1, M_SHL,  0, 0, 0, 8'b0000, 4, 0);
        step(0, "piso4",     1, M_SHL,  0, 0, 0, 8'b0000, 4, 0);
        step(0, "mf_clr",    1, M_CLR,  0, 0, 0, 8'b0000, 0, 0);
        step(0, "mf_shl1",   1, M_SHL,  0, 1, 0, 8'b0001, 1, 0);
        step(0, "mf_shl2",   1, M_SHL,  0, 1, 0, 8'b0011, 2, 0);
        async_reset(0);
        release_rst();
        step(0, "refill1",   1, M_SHL,  0, 1, 0, 8'b0001, 1, 0);
        step(0, "refill2",   1, M_SHL,  0, 1, 0, 8'b0011, 2, 0);
        step(0, "refill3",   1, M_SHL,  0, 1, 0, 8'b0111, 3, 0);
        step(0, "refill4",   1, M_SHL,  0, 1, 0, 8'b1111, 4, 1);
        step(0, "refill_hd", 1, M_HOLD, 0, 0, 0, 8'b1111, 4, 0);

        // WIDTH=8 suite
        async_reset(1);
        release_rst();
        step(1, "w8_clr",    1, M_CLR,  0, 0, 0, 8'h00, 0, 0);
        step(1, "w8_shr1",   1, M_SHR,  1, 0, 0, 8'h80, 1, 0);
        step(1, "w8_shr2",   1, M_SHR,  0, 0, 0, 8'h40, 2, 0);
        step(1, "w8_shr3",   1, M_SHR,  1, 0, 0, 8'hA0, 3, 0);
        step(1, "w8_shr4",   1, M_SHR,  1, 0, 0, 8'hD0, 4, 0);
        step(1, "w8_shr5",   1, M_SHR,  0, 0, 0, 8'h68, 5, 0);
        step(1, "w8_shr6",   1, M_SHR,  0, 0, 0, 8'h34, 6, 0);
        step(1, "w8_shr7",   1, M_SHR,  1, 0, 0, 8'h9A, 7, 0);
        step(1, "w8_shr8",   1, M_SHR,  0, 0, 0, 8'h4D, 8, 1);
        step(1, "w8_hold",   1, M_HOLD, 0, 0, 0, 8'h4D, 8, 0);
        step(1, "w8_asr_p",  1, M_ASR,  0, 0, 0, 8'h26, 8, 0);
        step(1, "w8_load",   1, M_LOAD, 0, 0, 8'h96, 8'h96, 8, 0);
        step(1, "w8_asr_n",  1, M_ASR,  0, 0, 0, 8'hCB, 8, 0);
        step(1, "w8_rotl",   1, M_ROTL, 0, 0, 0, 8'h97, 8, 0);
        step(1, "w8_rotr",   1, M_ROTR, 0, 0, 0, 8'hCB, 8, 0);
        step(1, "w8_shl",    1, M_SHL,  0, 0, 0, 8'h96, 8, 0);
        step(1, "w8_en0clr", 0, M_CLR,  0, 0, 0, 8'h96, 8, 0);
        step(1, "w8_clr2",   1, M_CLR,  0, 0, 0, 8'h00, 0, 0);

        // WIDTH=2 suite
        async_reset(2);
        release_rst();
        step(2, "w2_load",   1, M_LOAD, 0, 0, 8'b10, 8'b10, 2, 0);
        step(2, "w2_asr",    1, M_ASR,  0, 0, 0, 8'b11, 2, 0);
        step(2, "w2_clr",    1, M_CLR,  0, 0, 0, 8'b00, 0, 0);
        step(2, "w2_shl1",   1, M_SHL,  0, 1, 0, 8'b01, 1, 0);
        step(2, "w2_shl2",   1, M_SHL,  0, 0, 0, 8'b10, 2, 1);
        async_reset(2);
        release_rst();
        step(2, "w2_shr1",   1, M_SHR,  1, 0, 0, 8'b10, 1, 0);
        step(2, "w2_shr2",   1, M_SHR,  1, 0, 0, 8'b11, 2, 1);
        step(2, "w2_shr3",   1, M_SHR,  0, 0, 0, 8'b01, 2, 0);
        step(2, "w2_rotr",   1, M_ROTR, 0, 0, 0, 8'b10, 2, 0);

        repeat (2) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
